buyruk_onbellegi: RTL and testbench
===================================

Name: buyruk_onbellegi

Overview:
- Direct-mapped instruction cache that answers the fetch stage's instruction-memory requests (responder side of the fetch↔cache handshake).
- Hits return one 32-bit instruction per cycle.
- Misses stall the response while a 4-word line is refilled from main memory over a simple request/valid interface.
- Also handles fetch cancellation on taken branches and whole-cache invalidation (fence.i).

Parameters:
SATIR_SAYISI, 64, number of cache lines (power of 2); index width = log2(SATIR_SAYISI)
SATIR_KELIME, 4, 32-bit words per line (fixed 4; offset = ps[3:2], tag = ps[31:4+index width])

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
getir_istek_i  in  1  fetch request, level
getir_ps_i  in  32  fetch address; bits [1:0] ignored
getir_iptal_i  in  1  cancel the current/pending request (taken branch)
getir_gecerli_o  out  1  registered one-cycle pulse: getir_deger_o valid
getir_deger_o  out  32  instruction word
temizle_i  in  1  invalidate all lines
ana_istek_o  out  1  main-memory word read request
ana_adres_o  out  32  word address of the read, line-aligned base + 4*beat
ana_gecerli_i  in  1  memory returns a word this cycle
ana_veri_i  in  32  memory read data

Behaviour:
- Storage: data array SATIR_SAYISI x 4 x 32; tag array; valid bit per line.
- Tag/valid read is combinational on getir_ps_i.
- Reset (async):
  - State BOSTA; all valid bits 0.
  - getir_gecerli_o=0, getir_deger_o=0, ana_istek_o=0, ana_adres_o=0.
  - iptal/temizle pending flags 0; beat counter 0.
- States: BOSTA, DOLDUR, YANIT.
- BOSTA, acceptance:
  - A request is accepted on every rising edge with getir_istek_i=1.
  - Hit (valid and tag equal) and getir_iptal_i=0: next cycle getir_gecerli_o=1 with the word (latency 1); stay BOSTA; back-to-back hits give one word per cycle.
  - Miss and getir_iptal_i=0: latch PS; go to DOLDUR; ana_istek_o=1, ana_adres_o={ps[31:4],4'h0}, beat=0.
  - getir_iptal_i=1 with the request: request dropped, no response, no refill.
- DOLDUR:
  - ana_istek_o stays 1.
  - On each edge with ana_gecerli_i=1: write ana_veri_i to word[beat], beat+1, ana_adres_o+4.
  - ana_gecerli_i is ignored when ana_istek_o=0.
  - After beat 3 is captured: write tag and set valid for the line; ana_istek_o=0 next cycle; go to YANIT.
  - getir_istek_i and getir_ps_i are ignored; fetch holds them stable.
- YANIT:
  - If no pending iptal: getir_gecerli_o=1 with word[latched ps[3:2]].
  - If iptal pending: no pulse.
  - Return to BOSTA next cycle; clear iptal flag.
  - Miss latency = 4 memory beats + 2 cycles when memory answers every cycle (6 cycles from acceptance to pulse).
- getir_iptal_i while in DOLDUR/YANIT:
  - Sets the iptal flag; the refill always completes and the line is installed.
  - Response suppressed; a pulse already on getir_gecerli_o this cycle is not retracted.
- temizle_i:
  - In BOSTA: clears all valid bits at that edge; a request accepted in the same cycle is treated as a miss.
  - In DOLDUR/YANIT: latched and applied on the edge entering BOSTA, including the freshly refilled line.
  - Clearing takes one cycle regardless of SATIR_SAYISI.
- getir_gecerli_o is never high for two cycles for the same accepted request; it is 0 in every cycle not specified above.
- Reset mid-refill: immediate abort; ana_istek_o=0; the partial line stays invalid.

Test Plan:
- Cold miss: reset, getir_istek_i=1, ps=0x4; memory answers every cycle with 0xA0,0xA1,0xA2,0xA3 → ana_adres_o 0x0,0x4,0x8,0xC; single getir_gecerli_o pulse, deger=0xA1, 6 cycles after acceptance.
- Hits: then ps=0x0,0x4,0x8,0xC on consecutive cycles → four consecutive pulses 0xA0..0xA3; ana_istek_o stays 0.
- Conflict: ps=0x400 (index 0, new tag) → refill from 0x400; afterwards ps=0x0 misses again and refills from 0x0.
- Cancel: ps=0x100 miss, getir_iptal_i=1 during beat 2 → 4 beats complete, no pulse, back to BOSTA; then ps=0x104 → hit, pulse next cycle.
- Invalidate: after hits on 0x0, pulse temizle_i in BOSTA → next ps=0x0 misses and refills; temizle_i asserted during DOLDUR → the refilled line is also invalid afterwards.
- Async reset after 2 beats → ana_istek_o and getir_gecerli_o drop without waiting for a clock edge; the same address misses later.

Source files
------------

// File: rtl/buyruk_onbellegi.sv
// rtl/buyruk_onbellegi.sv - direct-mapped instruction cache with 4-word line refill
// Serves fetch requests on hits in one cycle; misses stall while the line is refilled.
module buyruk_onbellegi #(
  parameter int SATIR_SAYISI = 64,
  parameter int SATIR_KELIME = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        getir_istek_i,
  input  logic [31:0] getir_ps_i,
  input  logic        getir_iptal_i,
  output logic        getir_gecerli_o,
  output logic [31:0] getir_deger_o,
  input  logic        temizle_i,
  output logic        ana_istek_o,
  output logic [31:0] ana_adres_o,
  input  logic        ana_gecerli_i,
  input  logic [31:0] ana_veri_i
);

  localparam int IDX_W   = $clog2(SATIR_SAYISI);
  localparam int OFS_W   = $clog2(SATIR_KELIME);
  localparam int TAG_LSB = 2 + OFS_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    DOLDUR = 2'd1,
    YANIT  = 2'd2
  } durum_t;

  durum_t durum_q, durum_d;

  logic [SATIR_SAYISI-1:0] gecerli_q;
  logic [TAG_W-1:0]        etiket_mem [SATIR_SAYISI];
  logic [31:0]             veri_mem   [SATIR_SAYISI*SATIR_KELIME];

  logic [IDX_W-1:0] getir_idx, dolum_idx;
  logic [OFS_W-1:0] getir_ofs, dolum_ofs, beat_q;
  logic [TAG_W-1:0] getir_etiket, dolum_etiket;
  logic [31:0]      satir_taban;

  logic iptal_q, temizle_q;
  logic isabet, kabul, kabul_isabet, kabul_iskalama;
  logic yakala, son_beat, temizle_uygula, iptal_kaydet, temizle_kaydet;
  logic gecerli_d;
  logic [31:0] deger_d;

  // Byte-offset bits never select anything in a word-addressed cache.
  logic unused_ps;
  assign unused_ps = ^getir_ps_i[1:0];

  assign getir_ofs    = getir_ps_i[2 +: OFS_W];
  assign getir_idx    = getir_ps_i[2+OFS_W +: IDX_W];
  assign getir_etiket = getir_ps_i[31 -: TAG_W];
  assign satir_taban  = {getir_ps_i[31:2+OFS_W], {(2+OFS_W){1'b0}}};

  assign isabet = gecerli_q[getir_idx] && (etiket_mem[getir_idx] == getir_etiket);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q <= BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (kabul_iskalama) durum_d = DOLDUR;
      DOLDUR:  if (son_beat) durum_d = YANIT;
      YANIT:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    kabul          = 1'b0;
    kabul_isabet   = 1'b0;
    kabul_iskalama = 1'b0;
    yakala         = 1'b0;
    son_beat       = 1'b0;
    temizle_uygula = 1'b0;
    iptal_kaydet   = 1'b0;
    temizle_kaydet = 1'b0;
    gecerli_d      = 1'b0;
    deger_d        = getir_deger_o;
    case (durum_q)
      BOSTA: begin
        // A same-cycle invalidate makes the lookup miss even on a matching tag.
        kabul          = getir_istek_i && !getir_iptal_i;
        kabul_isabet   = kabul && isabet && !temizle_i;
        kabul_iskalama = kabul && !kabul_isabet;
        temizle_uygula = temizle_i;
        gecerli_d      = kabul_isabet;
        if (kabul_isabet) deger_d = veri_mem[{getir_idx, getir_ofs}];
      end
      DOLDUR: begin
        yakala         = ana_istek_o && ana_gecerli_i;
        son_beat       = yakala && (beat_q == '1);
        iptal_kaydet   = getir_iptal_i;
        temizle_kaydet = temizle_i;
      end
      YANIT: begin
        temizle_uygula = temizle_q || temizle_i;
        gecerli_d      = !(iptal_q || getir_iptal_i);
        if (gecerli_d) deger_d = veri_mem[{dolum_idx, dolum_ofs}];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      getir_gecerli_o <= 1'b0;
      getir_deger_o   <= '0;
      ana_istek_o     <= 1'b0;
      ana_adres_o     <= '0;
      beat_q          <= '0;
      iptal_q         <= 1'b0;
      temizle_q       <= 1'b0;
      gecerli_q       <= '0;
      dolum_idx       <= '0;
      dolum_ofs       <= '0;
      dolum_etiket    <= '0;
    end else begin
      getir_gecerli_o <= gecerli_d;
      getir_deger_o   <= deger_d;
      if (kabul_iskalama) begin
        ana_istek_o          <= 1'b1;
        ana_adres_o          <= satir_taban;
        beat_q               <= '0;
        dolum_idx            <= getir_idx;
        dolum_ofs            <= getir_ofs;
        dolum_etiket         <= getir_etiket;
        gecerli_q[getir_idx] <= 1'b0;
      end
      if (yakala) begin
        beat_q      <= beat_q + 1'b1;
        ana_adres_o <= ana_adres_o + 32'd4;
      end
      if (son_beat) begin
        ana_istek_o          <= 1'b0;
        gecerli_q[dolum_idx] <= 1'b1;
      end
      if (iptal_kaydet) iptal_q <= 1'b1;
      if (temizle_kaydet) temizle_q <= 1'b1;
      if (durum_q == YANIT) begin
        iptal_q   <= 1'b0;
        temizle_q <= 1'b0;
      end
      // Whole-cache clear wins over any single-line update in the same edge.
      if (temizle_uygula) gecerli_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (yakala) veri_mem[{dolum_idx, beat_q}] <= ana_veri_i;
    if (son_beat) etiket_mem[dolum_idx] <= dolum_etiket;
  end

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// tb/tb_buyruk_onbellegi.sv - directed and randomized checks of buyruk_onbellegi
module tb_buyruk_onbellegi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        getir_istek_i;
  logic [31:0] getir_ps_i;
  logic        getir_iptal_i;
  logic        getir_gecerli_o;
  logic [31:0] getir_deger_o;
  logic        temizle_i;
  logic        ana_istek_o;
  logic [31:0] ana_adres_o;
  logic        ana_gecerli_i;
  logic [31:0] ana_veri_i;

  int total = 0;
  int bad   = 0;

  // Reference: per-index line presence and owner tag.
  bit          mvalid [64];
  logic [21:0] mtag   [64];

  buyruk_onbellegi dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .getir_istek_i  (getir_istek_i),
    .getir_ps_i     (getir_ps_i),
    .getir_iptal_i  (getir_iptal_i),
    .getir_gecerli_o(getir_gecerli_o),
    .getir_deger_o  (getir_deger_o),
    .temizle_i      (temizle_i),
    .ana_istek_o    (ana_istek_o),
    .ana_adres_o    (ana_adres_o),
    .ana_gecerli_i  (ana_gecerli_i),
    .ana_veri_i     (ana_veri_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a < 32'h10) return 32'hA0 + (a >> 2);
    return (a ^ 32'h5EED_0000) + 32'h0000_1357;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] ps, input bit cancel_acc = 0, input bit clr_acc = 0,
                       input int cancel_beat = -1, input int clr_beat = -1,
                       input bit cancel_resp = 0, input bit gaps = 0);
    logic [5:0]  idx;
    logic [21:0] tag;
    logic [31:0] base;
    bit          hit, cancelled, clr;
    int          beat, cyc;
    idx  = ps[9:4];
    tag  = ps[31:10];
    base = {ps[31:4], 4'h0};
    getir_istek_i = 1'b1;
    getir_ps_i    = ps;
    getir_iptal_i = cancel_acc;
    temizle_i     = clr_acc;
    step();
    getir_istek_i = 1'b0;
    getir_iptal_i = 1'b0;
    temizle_i     = 1'b0;
    if (clr_acc) model_clear();
    hit = mvalid[idx] && (mtag[idx] == tag);
    if (cancel_acc) begin
      chk("cancel_acc_gecerli", getir_gecerli_o, 0);
      chk("cancel_acc_ana_istek", ana_istek_o, 0);
      return;
    end
    if (hit) begin
      chk("hit_gecerli", getir_gecerli_o, 1);
      chk("hit_deger", getir_deger_o, mem_fn({ps[31:2], 2'b00}));
      chk("hit_ana_istek", ana_istek_o, 0);
      return;
    end
    chk("miss_gecerli", getir_gecerli_o, 0);
    chk("miss_ana_istek", ana_istek_o, 1);
    mvalid[idx] = 1'b0;
    beat = 0;
    cyc = 0;
    cancelled = 0;
    clr = 0;
    while (beat < 4 && cyc < 40) begin
      chk("refill_adres", ana_adres_o, base + 32'(4 * beat));
      getir_iptal_i = (beat == cancel_beat);
      temizle_i     = (beat == clr_beat);
      cancelled     = cancelled || getir_iptal_i;
      clr           = clr || temizle_i;
      if (gaps && $urandom_range(3) == 0) begin
        ana_gecerli_i = 1'b0;
        ana_veri_i    = $urandom;
        step();
      end else begin
        ana_gecerli_i = 1'b1;
        ana_veri_i    = mem_fn(base + 32'(4 * beat));
        step();
        beat++;
      end
      cyc++;
      chk("refill_gecerli", getir_gecerli_o, 0);
      chk("refill_ana_istek", ana_istek_o, (beat < 4) ? 1 : 0);
    end
    if (beat < 4) chk("refill_timeout", beat, 4);
    ana_gecerli_i = 1'b0;
    temizle_i     = 1'b0;
    getir_iptal_i = cancel_resp;
    cancelled     = cancelled || cancel_resp;
    step();
    getir_iptal_i = 1'b0;
    mvalid[idx] = 1'b1;
    mtag[idx]   = tag;
    if (clr) model_clear();
    chk("resp_gecerli", getir_gecerli_o, cancelled ? 0 : 1);
    if (!cancelled) chk("resp_deger", getir_deger_o, mem_fn({ps[31:2], 2'b00}));
  endtask

  initial begin
    logic [31:0] ps;
    logic [21:0] t;
    rst_i = 1'b1;
    getir_istek_i = 1'b0;
    getir_ps_i    = '0;
    getir_iptal_i = 1'b0;
    temizle_i     = 1'b0;
    ana_gecerli_i = 1'b0;
    ana_veri_i    = '0;
    model_clear();
    step();
    step();
    chk("rst_gecerli", getir_gecerli_o, 0);
    chk("rst_deger", getir_deger_o, 0);
    chk("rst_ana_istek", ana_istek_o, 0);
    chk("rst_ana_adres", ana_adres_o, 0);
    rst_i = 1'b0;
    step();

    // Cold miss then back-to-back hits across the line
    fetch(32'h4);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    step();
    chk("idle_after_hits", getir_gecerli_o, 0);

    // Conflict on index 0
    fetch(32'h400);
    fetch(32'h408);
    fetch(32'h0);

    // Cancel during beat 2, line still installed
    fetch(32'h100, 0, 0, 2);
    step();
    chk("cancel_no_late_pulse", getir_gecerli_o, 0);
    fetch(32'h104);

    // Invalidate in idle, then during refill
    fetch(32'h0);
    temizle_i = 1'b1;
    step();
    temizle_i = 1'b0;
    model_clear();
    fetch(32'h0);
    fetch(32'h10);
    fetch(32'h10, 0, 0, -1, 1);
    fetch(32'h10);
    fetch(32'h0, 0, 1);
    fetch(32'h0);

    // Randomized traffic with gaps, cancels and invalidates
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(2))
        0: t = 22'h0;
        1: t = 22'h1;
        default: t = 22'h2ABCDE;
      endcase
      ps = {t, 6'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3))};
      fetch(ps, ($urandom_range(9) == 0), ($urandom_range(14) == 0),
            int'($urandom_range(9)), int'($urandom_range(15)),
            ($urandom_range(9) == 0), 1'b1);
    end

    // Async reset while a hit pulse is on the output
    fetch(32'h4);
    fetch(32'h4);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_gecerli", getir_gecerli_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();

    // Async reset two beats into a refill
    getir_istek_i = 1'b1;
    getir_ps_i    = 32'h200;
    step();
    getir_istek_i = 1'b0;
    chk("abort_miss_ana_istek", ana_istek_o, 1);
    for (int b = 0; b < 2; b++) begin
      ana_gecerli_i = 1'b1;
      ana_veri_i    = mem_fn(32'h200 + 32'(4 * b));
      step();
    end
    ana_gecerli_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("abort_ana_istek", ana_istek_o, 0);
    chk("abort_ana_adres", ana_adres_o, 0);
    chk("abort_gecerli", getir_gecerli_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
    fetch(32'h200);
    fetch(32'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
